// File: rtl/tlb_pkg.sv
// Shared widths, field offsets and INVTLB op codes for the TLB.
package tlb_pkg;

  localparam int VPPN_W = 19;
  localparam int PS_W   = 6;
  localparam int ASID_W = 10;
  localparam int PPN_W  = 20;
  localparam int PLV_W  = 2;
  localparam int MAT_W  = 2;

  // One page half: {ppn, plv, mat, d, v}
  localparam int HALF_W  = PPN_W + PLV_W + MAT_W + 2;
  localparam int ENTRY_W = 1 + VPPN_W + PS_W + ASID_W + 1 + 2 * HALF_W;
  localparam int RES_W   = PPN_W + PS_W + PLV_W + MAT_W + 2;

  // Entry field offsets (MSB first: e, vppn, ps, asid, g, half0, half1)
  localparam int E_OFF     = ENTRY_W - 1;
  localparam int VPPN_LSB  = E_OFF - VPPN_W;
  localparam int PS_LSB    = VPPN_LSB - PS_W;
  localparam int ASID_LSB  = PS_LSB - ASID_W;
  localparam int G_OFF     = ASID_LSB - 1;
  localparam int HALF0_LSB = HALF_W;
  localparam int HALF1_LSB = 0;

  // Result field offsets: {ppn, ps, plv, mat, d, v}
  localparam int RES_PPN_LSB = RES_W - PPN_W;
  localparam int RES_PS_LSB  = RES_PPN_LSB - PS_W;

  localparam logic [PS_W-1:0] PS_4M = 6'd21;
  localparam logic [PS_W-1:0] PS_4K = 6'd12;

  typedef enum logic [4:0] {
    INV_ALL0       = 5'd0,
    INV_ALL1       = 5'd1,
    INV_G1         = 5'd2,
    INV_G0         = 5'd3,
    INV_G0_ASID    = 5'd4,
    INV_G0_ASID_VA = 5'd5,
    INV_GA_VA      = 5'd6
  } inv_op_e;

  localparam logic [4:0] INV_OP_MAX = 5'd6;

  // Virtual page compare: a 4MB page ignores the low nine vppn bits.
  function automatic logic vppn_hit(input logic [VPPN_W-1:0] entry_vppn,
                                    input logic ps4mb,
                                    input logic [VPPN_W-1:0] q_vppn);
    return (entry_vppn[18:9] == q_vppn[18:9]) &&
           (ps4mb || (entry_vppn[8:0] == q_vppn[8:0]));
  endfunction

  // A half is {ppn, plv, mat, d, v}; the result inserts ps after ppn.
  function automatic logic [RES_W-1:0] make_res(input logic [HALF_W-1:0] half,
                                                input logic ps4mb);
    return {half[HALF_W-1:HALF_W-PPN_W], (ps4mb ? PS_4M : PS_4K),
            half[HALF_W-PPN_W-1:0]};
  endfunction

endpackage

// File: rtl/tlb_gen2_if.sv
// Search-port bundle: NPORT independent lookups packed side by side.
interface tlb_gen2_if
  import tlb_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int IDXW  = 4
);
  logic [NPORT-1:0]        s_req;
  logic [VPPN_W*NPORT-1:0] s_vppn;
  logic [NPORT-1:0]        s_va_bit12;
  logic [ASID_W*NPORT-1:0] s_asid;
  logic [NPORT-1:0]        s_valid;
  logic [NPORT-1:0]        s_found;
  logic [NPORT-1:0]        s_multi;
  logic [IDXW*NPORT-1:0]   s_index;
  logic [RES_W*NPORT-1:0]  s_res;

  modport master (
    output s_req, s_vppn, s_va_bit12, s_asid,
    input  s_valid, s_found, s_multi, s_index, s_res
  );

  modport slave (
    input  s_req, s_vppn, s_va_bit12, s_asid,
    output s_valid, s_found, s_multi, s_index, s_res
  );
endinterface

// File: rtl/tlb_match.sv
// Single entry against single search port hit test.
module tlb_match
  import tlb_pkg::*;
(
  input  logic              e,
  input  logic [VPPN_W-1:0] entry_vppn,
  input  logic              ps4mb,
  input  logic [ASID_W-1:0] entry_asid,
  input  logic              g,
  input  logic [VPPN_W-1:0] q_vppn,
  input  logic [ASID_W-1:0] q_asid,
  output logic              match
);
  // Global entries ignore the ASID compare.
  assign match = e && vppn_hit(entry_vppn, ps4mb, q_vppn) &&
                 (g || (entry_asid == q_asid));
endmodule

// File: rtl/tlb_gen2.sv
// Fully associative TLB with NPORT registered search ports, indexed or
// fill-pointer writes, combinational read and INVTLB invalidation.
module tlb_gen2
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int NPORT  = 2,
  localparam int IDXW  = $clog2(TLBNUM)
) (
  input  logic               clk,
  input  logic               rst,
  tlb_gen2_if.slave          s,
  input  logic               we,
  input  logic               fill,
  input  logic [IDXW-1:0]    w_index,
  input  logic [ENTRY_W-1:0] w_entry,
  output logic [IDXW-1:0]    fill_ptr,
  input  logic [IDXW-1:0]    r_index,
  output logic [ENTRY_W-1:0] r_entry,
  input  logic               inv_valid,
  input  logic [4:0]         inv_op,
  input  logic [ASID_W-1:0]  inv_asid,
  input  logic [VPPN_W-1:0]  inv_vppn,
  output logic               inv_err
);

  // Valid bits live in flops with reset; the rest of each entry is plain
  // storage that never needs clearing.
  logic [TLBNUM-1:0] e_reg;
  logic [TLBNUM-1:0] g_mem;
  logic [TLBNUM-1:0] ps4mb_mem;
  logic [VPPN_W-1:0] vppn_mem [TLBNUM];
  logic [ASID_W-1:0] asid_mem [TLBNUM];
  logic [HALF_W-1:0] half0_mem [TLBNUM];
  logic [HALF_W-1:0] half1_mem [TLBNUM];

  logic [IDXW-1:0]   fill_ptr_reg;
  logic              inv_err_reg;
  logic [IDXW-1:0]   w_addr;
  logic [TLBNUM-1:0] inv_hit;

  logic [NPORT-1:0][TLBNUM-1:0] match_vec;
  logic [NPORT-1:0]             found_next;
  logic [NPORT-1:0]             multi_next;
  logic [NPORT-1:0][IDXW-1:0]   index_next;
  logic [NPORT-1:0][RES_W-1:0]  res_next;

  logic [NPORT-1:0]             valid_reg;
  logic [NPORT-1:0]             found_reg;
  logic [NPORT-1:0]             multi_reg;
  logic [NPORT-1:0][IDXW-1:0]   index_reg;
  logic [NPORT-1:0][RES_W-1:0]  res_reg;

  assign w_addr = fill ? fill_ptr_reg : w_index;

  // Entry payload storage; ps collapses to a single 4MB flag.
  always_ff @(posedge clk) begin
    if (we) begin
      vppn_mem[w_addr]  <= w_entry[VPPN_LSB +: VPPN_W];
      ps4mb_mem[w_addr] <= (w_entry[PS_LSB +: PS_W] == PS_4M);
      asid_mem[w_addr]  <= w_entry[ASID_LSB +: ASID_W];
      g_mem[w_addr]     <= w_entry[G_OFF];
      half0_mem[w_addr] <= w_entry[HALF0_LSB +: HALF_W];
      half1_mem[w_addr] <= w_entry[HALF1_LSB +: HALF_W];
    end
  end

  // Per-entry invalidate selection for the current INVTLB op.
  always_comb begin
    inv_hit = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      case (inv_op)
        INV_ALL0, INV_ALL1: inv_hit[i] = 1'b1;
        INV_G1:             inv_hit[i] = g_mem[i];
        INV_G0:             inv_hit[i] = !g_mem[i];
        INV_G0_ASID:        inv_hit[i] = !g_mem[i] && (asid_mem[i] == inv_asid);
        INV_G0_ASID_VA:     inv_hit[i] = !g_mem[i] && (asid_mem[i] == inv_asid) &&
                                         vppn_hit(vppn_mem[i], ps4mb_mem[i], inv_vppn);
        INV_GA_VA:          inv_hit[i] = (g_mem[i] || (asid_mem[i] == inv_asid)) &&
                                         vppn_hit(vppn_mem[i], ps4mb_mem[i], inv_vppn);
        default:            inv_hit[i] = 1'b0;
      endcase
    end
  end

  // Valid bits, fill pointer and error pulse; a write to an entry wins
  // over an invalidate hitting the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_reg        <= '0;
      fill_ptr_reg <= '0;
      inv_err_reg  <= 1'b0;
    end else begin
      for (int i = 0; i < TLBNUM; i++) begin
        if (inv_valid && inv_hit[i]) e_reg[i] <= 1'b0;
        if (we && (w_addr == IDXW'(i))) e_reg[i] <= w_entry[E_OFF];
      end
      if (we && fill) fill_ptr_reg <= fill_ptr_reg + 1'b1;
      inv_err_reg <= inv_valid && (inv_op > INV_OP_MAX);
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_port
      for (gj = 0; gj < TLBNUM; gj++) begin : g_entry
        tlb_match u_match (
          .e          (e_reg[gj]),
          .entry_vppn (vppn_mem[gj]),
          .ps4mb      (ps4mb_mem[gj]),
          .entry_asid (asid_mem[gj]),
          .g          (g_mem[gj]),
          .q_vppn     (s.s_vppn[gi*VPPN_W +: VPPN_W]),
          .q_asid     (s.s_asid[gi*ASID_W +: ASID_W]),
          .match      (match_vec[gi][gj])
        );
      end
      assign s.s_index[gi*IDXW +: IDXW]   = index_reg[gi];
      assign s.s_res[gi*RES_W +: RES_W]   = res_reg[gi];
    end
  endgenerate

  // Lowest-index priority encode, multi-hit detect and half selection.
  always_comb begin
    found_next = '0;
    multi_next = '0;
    index_next = '0;
    res_next   = '0;
    for (int p = 0; p < NPORT; p++) begin
      for (int i = 0; i < TLBNUM; i++) begin
        if (match_vec[p][i]) begin
          if (found_next[p]) begin
            multi_next[p] = 1'b1;
          end else begin
            found_next[p] = 1'b1;
            index_next[p] = IDXW'(i);
          end
        end
      end
      if (found_next[p]) begin
        if (ps4mb_mem[index_next[p]] ? s.s_vppn[p*VPPN_W + 8] : s.s_va_bit12[p])
          res_next[p] = make_res(half1_mem[index_next[p]], ps4mb_mem[index_next[p]]);
        else
          res_next[p] = make_res(half0_mem[index_next[p]], ps4mb_mem[index_next[p]]);
      end
    end
  end

  // Search result registers: load on request, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      found_reg <= '0;
      multi_reg <= '0;
      index_reg <= '0;
      res_reg   <= '0;
    end else begin
      valid_reg <= s.s_req;
      for (int p = 0; p < NPORT; p++) begin
        if (s.s_req[p]) begin
          found_reg[p] <= found_next[p];
          multi_reg[p] <= multi_next[p];
          index_reg[p] <= index_next[p];
          res_reg[p]   <= res_next[p];
        end
      end
    end
  end

  assign s.s_valid = valid_reg;
  assign s.s_found = found_reg;
  assign s.s_multi = multi_reg;
  assign fill_ptr  = fill_ptr_reg;
  assign inv_err   = inv_err_reg;

  assign r_entry = {e_reg[r_index], vppn_mem[r_index],
                    (ps4mb_mem[r_index] ? PS_4M : PS_4K),
                    asid_mem[r_index], g_mem[r_index],
                    half0_mem[r_index], half1_mem[r_index]};

endmodule

// File: tb/tb_tlb_gen2.sv
// Directed bench for tlb_gen2: a 16-entry two-port instance for search,
// write and invalidate behaviour, plus a 4-entry instance for fill wrap.
module tb_tlb_gen2;
  import tlb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tlb_gen2_if #(.NPORT(2), .IDXW(4)) sif ();
  tlb_gen2_if #(.NPORT(1), .IDXW(2)) sif4 ();

  logic               we, fill, inv_valid, inv_err;
  logic [3:0]         w_index, r_index, fill_ptr;
  logic [ENTRY_W-1:0] w_entry, r_entry;
  logic [4:0]         inv_op;
  logic [ASID_W-1:0]  inv_asid;
  logic [VPPN_W-1:0]  inv_vppn;

  logic               we4, inv_err4;
  logic [1:0]         w_index4, r_index4, fill_ptr4;
  logic [ENTRY_W-1:0] w_entry4, r_entry4;

  tlb_gen2 #(.TLBNUM(16), .NPORT(2)) dut (
    .clk(clk), .rst(rst), .s(sif),
    .we(we), .fill(fill), .w_index(w_index), .w_entry(w_entry),
    .fill_ptr(fill_ptr), .r_index(r_index), .r_entry(r_entry),
    .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid),
    .inv_vppn(inv_vppn), .inv_err(inv_err)
  );

  tlb_gen2 #(.TLBNUM(4), .NPORT(1)) dut4 (
    .clk(clk), .rst(rst), .s(sif4),
    .we(we4), .fill(1'b1), .w_index(w_index4), .w_entry(w_entry4),
    .fill_ptr(fill_ptr4), .r_index(r_index4), .r_entry(r_entry4),
    .inv_valid(1'b0), .inv_op(5'd0), .inv_asid(10'd0),
    .inv_vppn(19'd0), .inv_err(inv_err4)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Fixed half-page attributes: half0 plv=1 mat=1 d=1 v=1, half1 plv=2 mat=2 d=0 v=1.
  function automatic logic [ENTRY_W-1:0] mk(input logic e, input logic [18:0] vppn,
                                            input logic [5:0] ps, input logic [9:0] asid,
                                            input logic g, input logic [19:0] ppn0,
                                            input logic [19:0] ppn1);
    return {e, vppn, ps, asid, g, ppn0, 2'd1, 2'd1, 1'b1, 1'b1,
            ppn1, 2'd2, 2'd2, 1'b0, 1'b1};
  endfunction

  function automatic logic [31:0] res0(input logic [19:0] ppn, input logic [5:0] ps);
    return {ppn, ps, 2'd1, 2'd1, 1'b1, 1'b1};
  endfunction

  function automatic logic [31:0] res1(input logic [19:0] ppn, input logic [5:0] ps);
    return {ppn, ps, 2'd2, 2'd2, 1'b0, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [ENTRY_W-1:0] ent);
    we = 1'b1; fill = 1'b0; w_index = idx; w_entry = ent;
    tick();
    we = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [18:0] v, input logic b12,
                          input logic [9:0] a);
    sif.s_vppn[p*19 +: 19] = v;
    sif.s_va_bit12[p]      = b12;
    sif.s_asid[p*10 +: 10] = a;
  endtask

  task automatic read_e(input logic [3:0] idx, output logic ev);
    r_index = idx;
    #1;
    ev = r_entry[E_OFF];
  endtask

  logic ev;
  logic [ENTRY_W-1:0] e3, e2, e7, e5, e10, e1;

  initial begin
    rst = 1'b1;
    we = 0; fill = 0; w_index = 0; w_entry = '0; r_index = 0;
    inv_valid = 0; inv_op = 0; inv_asid = 0; inv_vppn = 0;
    we4 = 0; w_index4 = 0; w_entry4 = '0; r_index4 = 0;
    sif.s_req = 2'b01; sif.s_vppn = '0; sif.s_va_bit12 = '0; sif.s_asid = '0;
    sif4.s_req = 1'b0; sif4.s_vppn = '0; sif4.s_va_bit12 = '0; sif4.s_asid = '0;

    // Reset state, with a search requested during reset
    tick(); tick();
    check("rst_valid", sif.s_valid, 2'b00);
    check("rst_found", sif.s_found, 2'b00);
    check("rst_fill_ptr", fill_ptr, 4'd0);
    check("rst_inv_err", inv_err, 1'b0);
    read_e(4'd0, ev);
    check("rst_e0", ev, 1'b0);
    sif.s_req = 2'b00;
    rst = 1'b0;
    tick();

    // Basic 4KB hit on both halves
    e3 = mk(1'b1, 19'h12345, 6'd12, 10'd5, 1'b0, 20'hABCDE, 20'h11111);
    wr(4'd3, e3);
    r_index = 4'd3; #1;
    check("rd_entry3", r_entry, e3);
    set_port(0, 19'h12345, 1'b0, 10'd5);
    set_port(1, 19'h12345, 1'b1, 10'd5);
    sif.s_req = 2'b11;
    tick();
    sif.s_req = 2'b00;
    check("hit_valid", sif.s_valid, 2'b11);
    check("hit_found", sif.s_found, 2'b11);
    check("hit_multi", sif.s_multi, 2'b00);
    check("hit_index0", sif.s_index[3:0], 4'd3);
    check("hit_index1", sif.s_index[7:4], 4'd3);
    check("hit_res0", sif.s_res[31:0], res0(20'hABCDE, 6'd12));
    check("hit_res1", sif.s_res[63:32], res1(20'h11111, 6'd12));
    tick();
    check("hold_valid", sif.s_valid, 2'b00);
    check("hold_found", sif.s_found, 2'b11);
    set_port(0, 19'h12345, 1'b0, 10'd6);
    sif.s_req = 2'b01;
    tick();
    sif.s_req = 2'b00;
    check("miss_valid", sif.s_valid, 2'b01);
    check("miss_found", sif.s_found, 2'b10);
    check("miss_index", sif.s_index[3:0], 4'd0);

    // Two global 4MB entries: lowest index wins, multi flagged, odd half
    e2 = mk(1'b1, 19'h2A100, 6'd21, 10'd1, 1'b1, 20'h22220, 20'h22221);
    e7 = mk(1'b1, 19'h2A100, 6'd21, 10'd2, 1'b1, 20'h77770, 20'h77771);
    wr(4'd2, e2);
    wr(4'd7, e7);
    set_port(0, 19'h2A1FF, 1'b0, 10'd9);
    sif.s_req = 2'b01;
    tick();
    sif.s_req = 2'b00;
    check("mh_found", sif.s_found[0], 1'b1);
    check("mh_multi", sif.s_multi[0], 1'b1);
    check("mh_index", sif.s_index[3:0], 4'd2);
    check("mh_res", sif.s_res[31:0], res1(20'h22221, 6'd21));

    // Unsupported page size is stored as 4KB
    e5 = mk(1'b1, 19'h00400, 6'd14, 10'd3, 1'b0, 20'h55550, 20'h55551);
    wr(4'd5, e5);
    r_index = 4'd5; #1;
    check("ps14_as_12", r_entry, mk(1'b1, 19'h00400, 6'd12, 10'd3, 1'b0, 20'h55550, 20'h55551));

    // INVTLB op 4 (g=0 & asid) and unsupported op 9
    wr(4'd8, mk(1'b1, 19'h01000, 6'd12, 10'd5, 1'b0, 20'h88880, 20'h88881));
    wr(4'd9, mk(1'b1, 19'h02000, 6'd12, 10'd5, 1'b1, 20'h99990, 20'h99991));
    e10 = mk(1'b1, 19'h30000, 6'd12, 10'd6, 1'b0, 20'hAAAA0, 20'hAAAA1);
    wr(4'd10, e10);
    inv_valid = 1'b1; inv_op = 5'd4; inv_asid = 10'd5;
    tick();
    inv_valid = 1'b0;
    check("op4_err", inv_err, 1'b0);
    read_e(4'd8, ev);  check("op4_e8", ev, 1'b0);
    read_e(4'd9, ev);  check("op4_e9", ev, 1'b1);
    read_e(4'd10, ev); check("op4_e10", ev, 1'b1);
    read_e(4'd3, ev);  check("op4_e3", ev, 1'b0);
    read_e(4'd2, ev);  check("op4_e2", ev, 1'b1);
    inv_valid = 1'b1; inv_op = 5'd9;
    tick();
    inv_valid = 1'b0;
    check("op9_err", inv_err, 1'b1);
    read_e(4'd9, ev);  check("op9_e9", ev, 1'b1);
    read_e(4'd10, ev); check("op9_e10", ev, 1'b1);
    tick();
    check("op9_err_pulse", inv_err, 1'b0);

    // Write + invalidate-all + search in one cycle
    e1 = mk(1'b1, 19'h44444, 6'd12, 10'd7, 1'b0, 20'h44440, 20'h44441);
    we = 1'b1; fill = 1'b0; w_index = 4'd1; w_entry = e1;
    inv_valid = 1'b1; inv_op = 5'd0;
    set_port(0, 19'h30000, 1'b0, 10'd6);
    sif.s_req = 2'b01;
    tick();
    we = 1'b0; inv_valid = 1'b0; sif.s_req = 2'b00;
    check("conc_found", sif.s_found[0], 1'b1);
    check("conc_index", sif.s_index[3:0], 4'd10);
    check("conc_res", sif.s_res[31:0], res0(20'hAAAA0, 6'd12));
    read_e(4'd1, ev);  check("conc_e1", ev, 1'b1);
    read_e(4'd10, ev); check("conc_e10", ev, 1'b0);
    read_e(4'd9, ev);  check("conc_e9", ev, 1'b0);
    read_e(4'd2, ev);  check("conc_e2", ev, 1'b0);
    set_port(1, 19'h44444, 1'b1, 10'd7);
    sif.s_req = 2'b10;
    tick();
    sif.s_req = 2'b00;
    check("new1_index", sif.s_index[7:4], 4'd1);
    check("new1_res", sif.s_res[63:32], res1(20'h44441, 6'd12));

    // One fill on the big instance advances the pointer
    we = 1'b1; fill = 1'b1; w_entry = mk(1'b1, 19'h55555, 6'd12, 10'd8, 1'b0, 20'h1, 20'h2);
    tick();
    we = 1'b0; fill = 1'b0;
    check("fill1_ptr", fill_ptr, 4'd1);
    read_e(4'd0, ev); check("fill1_e0", ev, 1'b1);

    // Asynchronous reset in the middle of a running search
    set_port(0, 19'h44444, 1'b0, 10'd7);
    sif.s_req = 2'b01;
    tick();
    check("pre_rst_valid", sif.s_valid[0], 1'b1);
    rst = 1'b1;
    #1;
    check("arst_valid", sif.s_valid, 2'b00);
    check("arst_found", sif.s_found, 2'b00);
    check("arst_fill_ptr", fill_ptr, 4'd0);
    read_e(4'd1, ev); check("arst_e1", ev, 1'b0);
    tick();
    check("arst_hold_valid", sif.s_valid, 2'b00);
    sif.s_req = 2'b00;
    rst = 1'b0;
    tick();

    // Five fills on the 4-entry instance: indices 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      logic [1:0] exp_idx;
      exp_idx = (k == 4) ? 2'd0 : 2'(k);
      check($sformatf("fill%0d_idx", k), fill_ptr4, exp_idx);
      we4 = 1'b1;
      w_entry4 = mk(1'b1, 19'h00100 + 19'(k), 6'd12, 10'd1, 1'b0, 20'h0, 20'h0);
      tick();
      we4 = 1'b0;
    end
    check("fill_ptr_final", fill_ptr4, 2'd1);
    r_index4 = 2'd0; #1;
    check("fill_wrap_vppn0", r_entry4[VPPN_LSB +: VPPN_W], 19'h00104);
    r_index4 = 2'd1; #1;
    check("fill_vppn1", r_entry4[VPPN_LSB +: VPPN_W], 19'h00101);
    r_index4 = 2'd3; #1;
    check("fill_vppn3", r_entry4[VPPN_LSB +: VPPN_W], 19'h00103);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/tlb_gen2.md
TLB_GEN2 -- requirements
Module: tlb_gen2

Interface
REQ-001 The block SHALL take parameter TLBNUM, default 16, as the entry count (power of 2, 4..64).
REQ-002 The block SHALL take parameter NPORT, default 2, as the number of independent search ports (1..4).
REQ-003 The block SHALL derive IDXW = clog2(TLBNUM); ENTRY_W=89 and RES_W=32 SHALL come from the package.
REQ-004 The block SHALL have these ports:
- clk  in  1  clock; everything updates on rising edge
- rst  in  1  asynchronous active-high reset
- s_req  in  NPORT  search request per port
- s_vppn  in  19*NPORT  VA[31:13] per port
- s_va_bit12  in  NPORT  VA[12] per port
- s_asid  in  10*NPORT  ASID per port
- s_valid  out  NPORT  result valid, one cycle after s_req
- s_found  out  NPORT  hit
- s_multi  out  NPORT  two or more entries matched
- s_index  out  IDXW*NPORT  lowest matching index
- s_res  out  RES_W*NPORT  {ppn[19:0],ps[5:0],plv[1:0],mat[1:0],d,v}
- we  in  1  write enable
- fill  in  1  qualifies we: use internal fill pointer (TLBFILL)
- w_index  in  IDXW  write index when fill=0
- w_entry  in  ENTRY_W  {e,vppn19,ps6,asid10,g,ppn0 20,plv0 2,mat0 2,d0,v0,ppn1 20,plv1 2,mat1 2,d1,v1}
- fill_ptr  out  IDXW  index the next fill will use
- r_index  in  IDXW  read index
- r_entry  out  ENTRY_W  combinational read of entry r_index, same layout
- inv_valid  in  1  INVTLB strobe
- inv_op  in  5  INVTLB op
- inv_asid  in  10  INVTLB ASID operand
- inv_vppn  in  19  INVTLB VA operand
- inv_err  out  1  one-cycle pulse: unsupported op

Function
REQ-005 Entry i SHALL match port p iff e[i] & vppn[18:9] equal & (ps4MB[i] | vppn[8:0] equal) & (asid equal | g[i]).
REQ-006 s_found SHALL be OR of matches; s_index the lowest matching index (0 on miss); s_multi set when ≥2 match.
REQ-007 Page half SHALL be selected by vppn[8] when entry ps=21, else by va_bit12; s_res carries that half's fields and ps 21/12.
REQ-008 Search outputs SHALL be registered: on cycle with s_req[p]=1, port p results load at the edge; s_valid[p] equals s_req[p] delayed one cycle; results hold when s_req[p]=0.
REQ-009 A search in the same cycle as a write or invalidate SHALL see pre-update contents.
REQ-010 Write with we=1 SHALL store w_entry at w_index (fill=0) or fill_ptr (fill=1); ps stored 4MB iff w_entry.ps=21, any other value stored as 12.
REQ-011 fill_ptr SHALL increment modulo TLBNUM on every we&fill, wrapping TLBNUM-1 -> 0.
REQ-012 With inv_valid=1, e SHALL clear at the edge for: op 0/1 all; 2 g=1; 3 g=0; 4 g=0&asid; 5 g=0&asid&va; 6 (g|asid)&va; va per REQ-005 VPPN rule using inv_vppn.
REQ-013 inv_op>6 with inv_valid SHALL change no entry and pulse inv_err for one cycle.
REQ-014 Simultaneous we and inv_valid: written entry SHALL take w_entry.e; invalidate applies to all other entries.
REQ-015 r_entry SHALL reflect stored contents combinationally, ps expanded to 21/12.

Reset
REQ-016 rst SHALL asynchronously clear all e bits, fill_ptr, s_valid, s_found, s_multi, s_index, s_res, inv_err to 0; other entry fields are not reset.
REQ-017 A search requested in the reset cycle SHALL produce no s_valid.

Structure
REQ-018 Package tlb_pkg SHALL hold field widths, ENTRY_W, RES_W, entry/result field offsets and INVTLB op constants.
REQ-019 Per-entry comparison SHALL be sub-module tlb_match, instantiated TLBNUM×NPORT.

Verification
REQ-020 Write idx 3 {e=1,vppn=0x12345,ps=12,asid=5,g=0,v0=1,ppn0=0xABCDE}; search vppn 0x12345,bit12=0,asid 5 -> next cycle valid=1,found=1,index=3,ppn=0xABCDE.
REQ-021 Entries 2 and 7 both g=1 same vppn, ps=21; search with vppn[8]=1 -> index=2, multi=1, ppn1 of entry 2, ps=21.
REQ-022 Five fills after reset (TLBNUM=4) -> indices 0,1,2,3,0; fill_ptr=1.
REQ-023 Op 4 asid 5 with entries {g=0,asid5},{g=1,asid5},{g=0,asid6} -> only first cleared; op 9 -> no change, inv_err=1 one cycle.
REQ-024 Same-cycle we idx 1 (e=1) and op 0 -> entry 1 e=1, all others 0; concurrent search returns old hit.
REQ-025 Assert rst mid-search -> s_valid and e cleared immediately, fill_ptr=0.
